// File: rtl/tensor_core_result_reader.sv
// Tensor core result reader: snapshots a 4x4 result matrix on the rising edge
// of the MMA done flag and streams its 16 elements over a valid/ready port.
// Optional build macro TENSOR_CORE_READER_TRANSPOSE_EN selects column-major
// streaming order; the default build streams row-major.
//
//   state | meaning
//   IDLE  | waiting for a done rising edge, outputs parked at zero
//   DRAIN | streaming the snapshot, one element per accepted transfer
module tensor_core_result_reader (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  is_done_with_calculation,
  input  logic [3:0][3:0][7:0]  tensor_core_output,
  output logic [7:0]            result_out,
  output logic [3:0]            result_index_out,
  output logic                  result_valid_out,
  input  logic                  result_ready_in,
  output logic                  result_last_out,
  output logic                  busy_out,
  output logic                  overrun_out
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]           state;
  logic                 done_prev;
  logic [3:0]           count;
  logic [3:0][3:0][7:0] snapshot;

  logic       done_rise;
  logic       xfer;
  logic       final_xfer;
  logic       busy;
  logic [1:0] row_sel;
  logic [1:0] col_sel;
  logic [3:0] lin_idx;

  assign done_rise  = is_done_with_calculation & ~done_prev;
  assign busy       = (state == DRAIN);
  assign xfer       = busy & result_ready_in;
  assign final_xfer = xfer & (count == 4'd15);

`ifdef TENSOR_CORE_READER_TRANSPOSE_EN
  assign row_sel = count[1:0];
  assign col_sel = count[3:2];
  assign lin_idx = {count[1:0], count[3:2]};
`else
  assign row_sel = count[3:2];
  assign col_sel = count[1:0];
  assign lin_idx = count;
`endif

  // Edge detect, snapshot capture, element counter and sticky overrun flag.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state       <= IDLE;
      done_prev   <= 1'b0;
      count       <= 4'd0;
      snapshot    <= '0;
      overrun_out <= 1'b0;
    end else begin
      done_prev <= is_done_with_calculation;
      case (state)
        IDLE: begin
          if (done_rise) begin
            snapshot <= tensor_core_output;
            count    <= 4'd0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (final_xfer) begin
            // A new result landing exactly on the last transfer chains
            // straight into the next drain instead of being lost.
            count <= 4'd0;
            if (done_rise) begin
              snapshot <= tensor_core_output;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (xfer) begin
              count <= count + 4'd1;
            end
            if (done_rise) begin
              overrun_out <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output mux; everything reads zero outside DRAIN so reset values hold in IDLE.
  always_comb begin
    result_out       = 8'd0;
    result_index_out = 4'd0;
    result_last_out  = 1'b0;
    if (busy) begin
      result_out       = snapshot[row_sel][col_sel];
      result_index_out = lin_idx;
      result_last_out  = (count == 4'd15);
    end
  end

  assign result_valid_out = busy;
  assign busy_out         = busy;

endmodule
